// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Width of each per-requester accepted-word counter.
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StArb  = 2'd1,
    StHold = 2'd2
  } arb_state_e;

  // Saturating increment; the counter sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake and FIFO write-port signals of the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data;
  logic                          fifo_full_n;
  logic                          bram_rst_busy;

  // Requesters plus FIFO status side.
  modport master (
    output req_valid, req_data, fifo_full_n, bram_rst_busy,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_full_n, bram_rst_busy,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i.
module rr_pick #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] start_i,
  output logic                 found_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  // Walk offsets from the far end so the nearest hit from start_i wins.
  always_comb begin
    int j;
    j       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      j = (int'(start_i) + k) % int'(NUM_REQ);
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  fifo_wr_arbiter_if.slave              bus,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          granted,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  accept_cnt
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [BurstW-1:0]     burst_q, burst_d, burst_inc;
  logic [CNT_WIDTH-1:0]  accept_cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0]  accept_cnt_d [NUM_REQ];

  logic [ID_WIDTH-1:0]   start_idx;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  wr_ok;
  logic                  accept;

  // Scan begins one past the last served requester, wrapping at NUM_REQ.
  always_comb begin
    if (last_grant_q == ID_WIDTH'(NUM_REQ - 1)) begin
      start_idx = '0;
    end else begin
      start_idx = last_grant_q + ID_WIDTH'(1);
    end
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(ID_WIDTH)
  ) u_rr_pick (
    .req_i  (bus.req_valid),
    .start_i(start_idx),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  assign cur_valid = bus.req_valid[grant_id_q];
  assign cur_data  = bus.req_data[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
  assign wr_ok     = bus.fifo_full_n & ~bus.bram_rst_busy;

  // Handshake outputs: only the granted requester sees ready, payload passes straight through.
  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    accept           = 1'b0;
    if (state_q == StHold) begin
      bus.req_ready[grant_id_q] = wr_ok;
      accept                    = cur_valid & wr_ok;
      bus.fifo_wr_en            = accept;
      bus.fifo_wr_data          = {grant_id_q, cur_data};
    end
  end

  // Next-state: arbitration, burst accounting and BRAM-reset fallback.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    accept_cnt_d = accept_cnt_q;
    burst_inc    = burst_q + BurstW'(1);

    unique case (state_q)
      StInit: begin
        if (!bus.bram_rst_busy) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (bus.bram_rst_busy) begin
          state_d = StInit;
        end else if (pick_found) begin
          grant_id_d = pick_idx;
          burst_d    = '0;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (bus.bram_rst_busy) begin
          // A dropped grant counts as served so the next scan moves past it.
          state_d      = StInit;
          last_grant_d = grant_id_q;
        end else begin
          if (accept) begin
            burst_d                  = burst_inc;
            accept_cnt_d[grant_id_q] = sat_inc(accept_cnt_q[grant_id_q]);
          end
          if (!cur_valid || (accept && (burst_inc == BurstW'(MAX_BURST)))) begin
            state_d      = StArb;
            last_grant_d = grant_id_q;
          end
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInit;
      grant_id_q   <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      burst_q      <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        accept_cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        accept_cnt_q[i] <= accept_cnt_d[i];
      end
    end
  end

  assign grant_id = grant_id_q;
  assign granted  = (state_q == StHold);

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_cnt
    assign accept_cnt[g*CNT_WIDTH +: CNT_WIDTH] = accept_cnt_q[g];
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter using an expected-write scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int IW = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  logic [IW-1:0]   grant_id;
  logic            granted;
  logic [N*CW-1:0] accept_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (8),
    .ID_WIDTH  (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant_id  (grant_id),
    .granted   (granted),
    .accept_cnt(accept_cnt)
  );

  int   word_idx [N];
  int   word_lim [N];
  logic full_n;
  logic busy;

  logic [IW+DW-1:0] exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   wr_cnt   = 0;
  int   last_wr_cyc = -1;
  logic [IW-1:0] last_tag = '0;
  bit   gap_chk = 1'b0;

  function automatic logic [DW-1:0] payload(int i, int k);
    return DW'(i * 65536 + k);
  endfunction

  function automatic logic [IW+DW-1:0] word(int i, int k);
    return {IW'(i), payload(i, k)};
  endfunction

  function automatic logic [63:0] cnt_of(int i);
    return 64'(accept_cnt[i*CW +: CW]);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = (word_idx[i] < word_lim[i]);
      bus.req_data[i*DW +: DW]  = payload(i, word_idx[i]);
    end
    bus.fifo_full_n   = full_n;
    bus.bram_rst_busy = busy;
  endtask

  // Sample at negedge, advance one clock, then apply new stimulus.
  task automatic cycle();
    logic [N-1:0]  hs;
    logic [IW-1:0] tag;
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    if (bus.fifo_wr_en) begin
      check_val("wr_expected", {62'd0, bus.fifo_wr_en, exp_q.size() != 0}, 64'd3);
      if (exp_q.size() != 0) begin
        check_val("wr_data", 64'(bus.fifo_wr_data), 64'(exp_q.pop_front()));
      end
      tag = bus.fifo_wr_data[IW+DW-1 -: IW];
      if (gap_chk && last_wr_cyc >= 0 && tag != last_tag) begin
        check_val("grant_gap", 64'(cyc - last_wr_cyc), 64'd2);
      end
      last_tag    = tag;
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) word_idx[i]++;
    end
    drive();
    #1;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_until_writes(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check_val({tag, "_writes"}, 64'(wr_cnt), 64'(target));
  endtask

  task automatic do_reset(input logic busy_v);
    reset  = 1'b1;
    full_n = 1'b1;
    busy   = busy_v;
    for (int i = 0; i < N; i++) begin
      word_idx[i] = 0;
      word_lim[i] = 0;
    end
    exp_q.delete();
    gap_chk     = 1'b0;
    last_wr_cyc = -1;
    wr_cnt      = 0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int seq [5];
    int base [N];
    bit stalled;
    int n;

    reset = 1'b1;

    // Reset plus BRAM busy for five cycles, then INIT exits.
    do_reset(1'b1);
    word_lim[0] = 3;
    drive();
    #1;
    check_val("rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check_val("rst_granted", 64'(granted), 64'd0);
    check_val("rst_grant_id", 64'(grant_id), 64'd0);
    check_val("rst_cnt", 64'(accept_cnt), 64'd0);
    for (int k = 0; k < 3; k++) exp_q.push_back(word(0, k));
    for (int c = 0; c < 5; c++) begin
      cycle();
      check_val("init_ready", 64'(bus.req_ready), 64'd0);
      check_val("init_granted", 64'(granted), 64'd0);
    end
    busy = 1'b0;
    drive();
    #1;
    cycle();
    check_val("arb_cycle_granted", 64'(granted), 64'd0);
    check_val("arb_cycle_ready", 64'(bus.req_ready), 64'd0);
    cycle();
    check_val("hold_granted", 64'(granted), 64'd1);
    check_val("hold_grant_id", 64'(grant_id), 64'd0);
    check_val("hold_ready", 64'(bus.req_ready), 64'd1);
    run_until_empty("init", 30);
    check_val("init_cnt0", cnt_of(0), 64'd3);

    // All four requesters valid: 0,1,2,3,0 with eight words each.
    do_reset(1'b0);
    seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      word_lim[i] = 1000;
      base[i]     = 0;
    end
    drive();
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(word(seq[g], base[seq[g]] + k));
      base[seq[g]] += 8;
    end
    gap_chk = 1'b1;
    run_until_empty("rr", 80);
    gap_chk = 1'b0;
    for (int i = 0; i < N; i++) word_lim[i] = word_idx[i];
    drive();
    #1;
    cycle();
    check_val("rr_idle_granted", 64'(granted), 64'd0);
    check_val("rr_cnt0", cnt_of(0), 64'd16);
    check_val("rr_cnt1", cnt_of(1), 64'd8);
    check_val("rr_cnt2", cnt_of(2), 64'd8);
    check_val("rr_cnt3", cnt_of(3), 64'd8);

    // Requester 2 alone, three words then valid drops.
    do_reset(1'b0);
    word_lim[2] = 3;
    drive();
    for (int k = 0; k < 3; k++) exp_q.push_back(word(2, k));
    run_until_empty("short", 30);
    cycle();
    cycle();
    check_val("short_granted", 64'(granted), 64'd0);
    check_val("short_cnt2", cnt_of(2), 64'd3);
    check_val("short_cnt0", cnt_of(0), 64'd0);

    // Requester 1 burst with a four-cycle FIFO-full stall after two words.
    do_reset(1'b0);
    word_lim[1] = 12;
    drive();
    for (int k = 0; k < 12; k++) exp_q.push_back(word(1, k));
    stalled = 1'b0;
    n = 0;
    while (wr_cnt < 8 && n < 60) begin
      cycle();
      n++;
      if (wr_cnt == 2 && !stalled) begin
        stalled = 1'b1;
        full_n  = 1'b0;
        drive();
        #1;
        for (int s = 0; s < 4; s++) begin
          check_val("stall_wr_en", 64'(bus.fifo_wr_en), 64'd0);
          check_val("stall_granted", 64'(granted), 64'd1);
          cycle();
        end
        full_n = 1'b1;
        drive();
        #1;
      end
    end
    check_val("stall_writes", 64'(wr_cnt), 64'd8);
    check_val("stall_rotate", 64'(granted), 64'd0);
    check_val("stall_cnt1", cnt_of(1), 64'd8);
    run_until_empty("stall", 40);
    check_val("stall_cnt1_total", cnt_of(1), 64'd12);

    // BRAM busy pulse during requester 3's burst; rescan starts at 0.
    do_reset(1'b0);
    word_lim[3] = 100;
    drive();
    for (int k = 0; k < 3; k++) exp_q.push_back(word(3, k));
    run_until_writes("busy", 3, 30);
    busy        = 1'b1;
    word_lim[0] = 2;
    word_lim[3] = word_idx[3] + 2;
    drive();
    #1;
    check_val("busy_ready", 64'(bus.req_ready), 64'd0);
    check_val("busy_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    cycle();
    check_val("busy_drop", 64'(granted), 64'd0);
    cycle();
    busy = 1'b0;
    drive();
    #1;
    exp_q.push_back(word(0, 0));
    exp_q.push_back(word(0, 1));
    exp_q.push_back(word(3, 3));
    exp_q.push_back(word(3, 4));
    run_until_empty("busy", 40);
    check_val("busy_cnt3", cnt_of(3), 64'd5);
    check_val("busy_cnt0", cnt_of(0), 64'd2);

    // Asynchronous reset between edges while holding a grant.
    do_reset(1'b0);
    word_lim[1] = 100;
    drive();
    exp_q.push_back(word(1, 0));
    exp_q.push_back(word(1, 1));
    run_until_writes("areset", 2, 30);
    check_val("areset_pre_cnt1", cnt_of(1), 64'd2);
    check_val("areset_pre_granted", 64'(granted), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("areset_granted", 64'(granted), 64'd0);
    check_val("areset_ready", 64'(bus.req_ready), 64'd0);
    check_val("areset_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check_val("areset_cnt", 64'(accept_cnt), 64'd0);
    exp_q.delete();
    cycle();
    check_val("areset_hold_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check_val("areset_hold_granted", 64'(granted), 64'd0);
    word_lim[1] = 0;
    drive();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
